// File: rtl/demux1to2v_stream_pkg.sv
// Shared constants for the 1-to-2 stream demux and its per-output buffers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux1to2v_stream_pkg;

    localparam int WIDTH_DEF = 100;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W     = 16;

    // Pointer width for a power-of-two buffer depth; pointers wrap naturally.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
    localparam int OCC_W_DEF = occ_w(DEPTH_DEF);

endpackage

// File: rtl/demux1to2v_stream_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits, head exposed combinationally.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push ignored while full (even with a same-edge pop); pop ignored while empty.
//
// Ports: clk, resetn (sync, active-low); push/push_data write side;
//        pop read side; full, empty status; head = oldest entry.
module stream_fifo
    import demux1to2v_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = occ_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             push_en;
    logic             pop_en;

    // Full is taken from registered occupancy, so a pop on the same edge
    // does not open a slot for a push: the input never sees the output ready.
    assign full    = (occ_q == OW'(DEPTH));
    assign empty   = (occ_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/demux1to2v_stream.sv
// Routes each input beat to stream a (in_sel=0) or b (in_sel=1) through a per-output FIFO.
// Latency: 1 cycle from accept edge to valid on the selected output.
// Backpressure: in_ready = selected buffer not full; independent of a_ready/b_ready.
//
// Ports: clk, resetn (sync, active-low); in_data/in_sel/in_valid/in_ready input stream;
//        a_data/a_valid/a_ready, b_data/b_valid/b_ready output streams;
//        a_cnt, b_cnt = 16-bit wrapping counts of beats delivered per output.
module demux1to2v_stream
    import demux1to2v_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic             full_a, empty_a, push_a, pop_a;
    logic             full_b, empty_b, push_b, pop_b;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    // Ready only looks at the buffer this beat targets, so a full b never
    // stalls traffic to a. Gated by resetn so nothing is accepted in reset.
    assign in_ready = resetn & (in_sel ? ~full_b : ~full_a);
    assign push_a   = in_valid & in_ready & ~in_sel;
    assign push_b   = in_valid & in_ready &  in_sel;

    assign a_valid  = ~empty_a;
    assign b_valid  = ~empty_b;
    assign pop_a    = a_valid & a_ready;
    assign pop_b    = b_valid & b_ready;

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_a),
        .push_data (in_data),
        .pop       (pop_a),
        .full      (full_a),
        .empty     (empty_a),
        .head      (a_data)
    );

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_b),
        .push_data (in_data),
        .pop       (pop_b),
        .full      (full_b),
        .empty     (empty_b),
        .head      (b_data)
    );

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (pop_a) a_cnt_d = a_cnt_q + CNT_W'(1);
        if (pop_b) b_cnt_d = b_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;

endmodule

// File: tb/tb_demux1to2v_stream.sv
module tb_demux1to2v_stream;

    localparam int W = 100;
    localparam int D = 2;

    logic          clk;
    logic          resetn;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [15:0]   a_cnt;
    logic [15:0]   b_cnt;

    int            checks = 0;
    int            errors = 0;

    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    logic [15:0]   exp_a_cnt = 16'd0;
    logic [15:0]   exp_b_cnt = 16'd0;

    demux1to2v_stream #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Scoreboard monitor: expected queues are filled from the stimulus side
    // and drained whenever an output beat is delivered.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!resetn) begin
            qa.delete();
            qb.delete();
            exp_a_cnt = 16'd0;
            exp_b_cnt = 16'd0;
            chk("rst_in_ready", W'(in_ready), W'(0));
        end else begin
            exp_rdy = in_sel ? (qb.size() < D) : (qa.size() < D);
            chk("in_ready", W'(in_ready), W'(exp_rdy));
            chk("a_valid", W'(a_valid), W'(qa.size() != 0));
            chk("b_valid", W'(b_valid), W'(qb.size() != 0));
            chk("a_cnt", W'(a_cnt), W'(exp_a_cnt));
            chk("b_cnt", W'(b_cnt), W'(exp_b_cnt));
            if (a_valid && qa.size() != 0) begin
                chk("a_data", a_data, qa[0]);
                if (a_ready) begin
                    void'(qa.pop_front());
                    exp_a_cnt = exp_a_cnt + 16'd1;
                end
            end
            if (b_valid && qb.size() != 0) begin
                chk("b_data", b_data, qb[0]);
                if (b_ready) begin
                    void'(qb.pop_front());
                    exp_b_cnt = exp_b_cnt + 16'd1;
                end
            end
            if (in_valid && exp_rdy) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted, then drop valid and scramble payload.
    task automatic send(input logic sel, input logic [W-1:0] d);
        int  budget;
        bit  done;
        budget   = 0;
        done     = 1'b0;
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else if (++budget > 200) begin
                fail_now("send_timeout");
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = {W{1'b1}};
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((qa.size() != 0 || qb.size() != 0) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 500) fail_now("drain_timeout");
        tick();
        tick();
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_b;

    initial begin
        int acc;
        int cyc;
        ones     = {W{1'b1}};
        pat_a    = {25{4'hA}};
        pat_b    = {25{4'h5}};
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("reset_a_valid", W'(a_valid), W'(0));
        chk("reset_b_valid", W'(b_valid), W'(0));
        chk("reset_a_data", a_data, W'(0));
        chk("reset_b_data", b_data, W'(0));
        chk("reset_a_cnt", W'(a_cnt), W'(0));
        chk("reset_b_cnt", W'(b_cnt), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(0));
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("first_cycle_ready", W'(in_ready), W'(1));
        tick();

        // Single all-ones beat to a
        a_ready = 1'b1;
        send(1'b0, ones);
        @(negedge clk);
        chk("ones_a_valid", W'(a_valid), W'(1));
        chk("ones_a_data", a_data, ones);
        chk("ones_b_valid", W'(b_valid), W'(0));
        tick();
        @(negedge clk);
        chk("ones_a_cnt", W'(a_cnt), W'(1));
        tick();

        // b stalled: two beats fill B, third refused, a still flows
        b_ready = 1'b0;
        send(1'b1, W'(1));
        send(1'b1, W'(2));
        in_sel   = 1'b1;
        in_data  = W'(3);
        in_valid = 1'b1;
        @(negedge clk);
        chk("b_full_ready", W'(in_ready), W'(0));
        tick();
        send(1'b0, W'(32'h55));
        @(negedge clk);
        chk("b_hold_valid", W'(b_valid), W'(1));
        chk("b_hold_data", b_data, W'(1));
        tick();
        b_ready = 1'b1;
        drain();
        send(1'b1, W'(3));
        drain();

        // A full with pop on the same edge: no push that edge
        a_ready = 1'b0;
        send(1'b0, W'(32'h10));
        send(1'b0, W'(32'h11));
        a_ready  = 1'b1;
        in_sel   = 1'b0;
        in_data  = W'(32'h12);
        in_valid = 1'b1;
        @(negedge clk);
        chk("a_full_pop_ready", W'(in_ready), W'(0));
        tick();
        send(1'b0, W'(32'h12));
        drain();

        // Reset mid-transfer with both buffers holding two beats
        a_ready = 1'b0;
        b_ready = 1'b0;
        send(1'b0, W'(32'h21));
        send(1'b0, W'(32'h22));
        send(1'b1, W'(32'h31));
        send(1'b1, W'(32'h32));
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = W'(32'h99);
        @(negedge clk);
        chk("midrst_in_ready", W'(in_ready), W'(0));
        tick();
        resetn   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_a_valid", W'(a_valid), W'(0));
        chk("midrst_b_valid", W'(b_valid), W'(0));
        chk("midrst_a_cnt", W'(a_cnt), W'(0));
        chk("midrst_b_cnt", W'(b_cnt), W'(0));
        tick();
        a_ready = 1'b1;
        b_ready = 1'b1;
        repeat (5) tick();

        // 100 alternating beats, both outputs always ready
        for (int i = 0; i < 100; i++) begin
            send(1'(i % 2), (i % 2 == 0) ? pat_a : pat_b);
        end
        drain();
        @(negedge clk);
        chk("alt_a_cnt", W'(a_cnt), W'(50));
        chk("alt_b_cnt", W'(b_cnt), W'(50));
        tick();

        // 65537 beats on a: counter wraps to 1
        resetn = 1'b0;
        tick();
        resetn   = 1'b1;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        acc      = 0;
        cyc      = 0;
        while (acc < 65537 && cyc < 70000) begin
            in_data = W'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 70000) fail_now("wrap_timeout");
        drain();
        @(negedge clk);
        chk("wrap_a_cnt", W'(a_cnt), W'(1));
        chk("wrap_b_cnt", W'(b_cnt), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
